// File: rtl/pr_pkg.sv
// Shared definitions for the peripheral register bridge: FSM encoding,
// default address map and the per-device word offsets.
package pr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CTRL   = 2'd0,
        PRESET = 2'd1,
        COUNT  = 2'd2
    } word_ofs_t;

    localparam logic [31:0] DEF_BASE   = 32'h0000_7F00;
    localparam int unsigned DEF_STRIDE = 16;
    localparam logic [31:0] ERR_RDATA  = 32'h0;

    // Width of a device select; a single device still needs one bit.
    function automatic int unsigned sel_width(input int unsigned ndev);
        return (ndev > 1) ? $clog2(ndev) : 1;
    endfunction

endpackage

// File: rtl/pr_bridge_if.sv
// CPU-side request/response and device-side register bus of the bridge.
// The slave modport is the bridge's view, master is the CPU/device side.
interface pr_bridge_if #(
    parameter int unsigned NDEV = 3
);
    logic                   cpu_req;
    logic                   cpu_we;
    logic [31:0]            cpu_addr;
    logic [31:0]            cpu_wdata;
    logic [31:0]            cpu_rdata;
    logic                   cpu_ready;
    logic                   cpu_err;
    logic [1:0]             dev_addr;
    logic [31:0]            dev_wdata;
    logic [NDEV-1:0]        dev_we;
    logic [NDEV*32-1:0]     dev_rdata;
    logic [NDEV-1:0]        dev_irq;
    logic [5:0]             hw_int;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_irq,
        output cpu_rdata, cpu_ready, cpu_err, dev_addr, dev_wdata, dev_we, hw_int
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_irq,
        input  cpu_rdata, cpu_ready, cpu_err, dev_addr, dev_wdata, dev_we, hw_int
    );

endinterface

// File: rtl/pr_decode.sv
// Combinational address decoder: device window hit, device select,
// interrupt-mask register hit, and error for everything else.
module pr_decode
    import pr_pkg::*;
#(
    parameter int unsigned NDEV   = 3,
    parameter logic [31:0] BASE   = DEF_BASE,
    parameter int unsigned STRIDE = DEF_STRIDE
)(
    input  logic [31:0]                 addr,
    output logic                        hit,
    output logic [sel_width(NDEV)-1:0]  sel,
    output logic                        is_mask,
    output logic                        err
);

    localparam logic [31:0] SPAN = 32'(NDEV * STRIDE);
    localparam logic [31:0] STR  = 32'(STRIDE);

    logic [31:0] off;

    // Addresses below BASE wrap to large offsets and so never hit.
    always_comb begin
        off     = addr - BASE;
        hit     = (off < SPAN) && (((off % STR) >> 2) <= 32'(COUNT));
        sel     = sel_width(NDEV)'(off / STR);
        is_mask = (addr == BASE + SPAN);
        err     = !hit && !is_mask;
    end

endmodule

// File: rtl/pr_bridge.sv
// MIPS data-memory to peripheral register bridge: fixed two-cycle access
// FSM, one-hot write strobes, read mux and a maskable interrupt vector.
module pr_bridge
    import pr_pkg::*;
#(
    parameter int unsigned NDEV   = 3,
    parameter logic [31:0] BASE   = DEF_BASE,
    parameter int unsigned STRIDE = DEF_STRIDE
)(
    input  logic        clk,
    input  logic        reset,
    pr_bridge_if.slave  bus
);

    localparam int unsigned SELW = sel_width(NDEV);

    state_t            state, state_nx;
    logic              dec_hit, dec_mask, dec_err;
    logic [SELW-1:0]   dec_sel;
    logic              lat_we, lat_hit, lat_mask, lat_err;
    logic [SELW-1:0]   lat_sel;
    logic [1:0]        addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [5:0]        mask_q;
    logic [5:0]        hw_int_q;
    logic              accept;
    logic              ready;
    logic              err;
    logic [NDEV-1:0]   we;
    logic [31:0]       rd_arr [NDEV];

    pr_decode #(.NDEV(NDEV), .BASE(BASE), .STRIDE(STRIDE)) u_decode (
        .addr    (bus.cpu_addr),
        .hit     (dec_hit),
        .sel     (dec_sel),
        .is_mask (dec_mask),
        .err     (dec_err)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Strobe and completion are gated by reset so an access caught by a
    // reset is dropped in that very cycle rather than one cycle later.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        ready    = 1'b0;
        err      = 1'b0;
        we       = '0;
        case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    accept   = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                state_nx = DONE;
                if (lat_we && lat_hit && !reset)
                    we = NDEV'(1) << lat_sel;
            end
            DONE: begin
                state_nx = IDLE;
                ready    = !reset;
                err      = lat_err && !reset;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NDEV; i++)
            rd_arr[i] = bus.dev_rdata[32*i +: 32];
    end

    // Datapath registers; the interrupt vector samples every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we   <= 1'b0;
            lat_hit  <= 1'b0;
            lat_mask <= 1'b0;
            lat_err  <= 1'b0;
            lat_sel  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mask_q   <= 6'b111111;
            hw_int_q <= '0;
        end else begin
            hw_int_q <= 6'(bus.dev_irq) & mask_q;
            if (accept) begin
                lat_we   <= bus.cpu_we;
                lat_hit  <= dec_hit;
                lat_mask <= dec_mask;
                lat_err  <= dec_err;
                lat_sel  <= dec_sel;
                addr_q   <= bus.cpu_addr[3:2];
                wdata_q  <= bus.cpu_wdata;
            end
            if (state == ACCESS) begin
                if (lat_err)
                    rdata_q <= ERR_RDATA;
                else if (!lat_we)
                    rdata_q <= lat_mask ? {26'b0, mask_q} : rd_arr[lat_sel];
                if (lat_we && lat_mask)
                    mask_q <= wdata_q[5:0];
            end
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_ready = ready;
    assign bus.cpu_err   = err;
    assign bus.dev_addr  = addr_q;
    assign bus.dev_wdata = wdata_q;
    assign bus.dev_we    = we;
    assign bus.hw_int    = hw_int_q;

endmodule

// File: tb/tb_pr_bridge.sv
// Self-checking bench for pr_bridge: directed scenarios followed by random
// accesses checked against an address-map model of the bridge.
module tb_pr_bridge;

    localparam int unsigned NDEV   = 3;
    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam int unsigned STRIDE = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [31:0] dev_vals [NDEV];
    logic [5:0]  mask_m;
    logic [31:0] rd_dummy;

    pr_bridge_if #(.NDEV(NDEV)) bus ();

    pr_bridge #(.NDEV(NDEV), .BASE(BASE), .STRIDE(STRIDE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_devs();
        bus.dev_rdata = {dev_vals[2], dev_vals[1], dev_vals[0]};
    endtask

    // Address map as a lookup: which device/word, or the mask register.
    task automatic ref_decode(input logic [31:0] a, output int dev, output int word, output bit is_mask);
        longint off;
        off     = longint'(a) - longint'(BASE);
        is_mask = (longint'(a) == longint'(BASE) + NDEV*STRIDE);
        dev     = -1;
        word    = 0;
        if (off >= 0 && off < NDEV*STRIDE && ((off % STRIDE) / 4) <= 2) begin
            dev  = int'(off / STRIDE);
            word = int'((off % STRIDE) / 4);
        end
    endtask

    // One full access; called at posedge+1 with the bridge idle, returns at
    // posedge+1 just after the DONE cycle. Optionally keeps cpu_req high.
    task automatic apply_stimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input bit keep_req, output logic [31:0] rdata);
        int          dev, word;
        bit          ism, exp_err;
        logic [31:0] exp_rd;
        logic [2:0]  exp_we;
        logic [5:0]  exp_int;
        ref_decode(addr, dev, word, ism);
        exp_err = (dev < 0) && !ism;
        exp_we  = (we && dev >= 0) ? 3'(1 << dev) : 3'b000;
        exp_rd  = exp_err ? 32'h0 : (ism ? {26'b0, mask_m} : dev_vals[(dev < 0) ? 0 : dev]);
        exp_int = 6'(bus.dev_irq) & mask_m;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(negedge clk);
        check_output("idle_ready", 32'(bus.cpu_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_output("access_we", 32'(bus.dev_we), 32'(exp_we));
        check_output("access_ready", 32'(bus.cpu_ready), 32'd0);
        if (dev >= 0) check_output("dev_addr", 32'(bus.dev_addr), 32'(word));
        if (we)       check_output("dev_wdata", bus.dev_wdata, wdata);
        @(posedge clk);
        @(negedge clk);
        check_output("done_ready", 32'(bus.cpu_ready), 32'd1);
        check_output("done_err", 32'(bus.cpu_err), 32'(exp_err));
        check_output("done_we", 32'(bus.dev_we), 32'd0);
        check_output("hw_int", 32'(bus.hw_int), 32'(exp_int));
        if (!we || exp_err) check_output("rdata", bus.cpu_rdata, exp_rd);
        rdata = bus.cpu_rdata;
        if (we && ism) mask_m = wdata[5:0];
        @(posedge clk);
        #1;
        if (!keep_req) bus.cpu_req = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dev_irq   = '0;
        for (int i = 0; i < NDEV; i++) dev_vals[i] = $urandom;
        load_devs();
        mask_m = 6'b111111;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_ready", 32'(bus.cpu_ready), 32'd0);
        check_output("rst_err", 32'(bus.cpu_err), 32'd0);
        check_output("rst_rdata", bus.cpu_rdata, 32'd0);
        check_output("rst_we", 32'(bus.dev_we), 32'd0);
        check_output("rst_daddr", 32'(bus.dev_addr), 32'd0);
        check_output("rst_dwdata", bus.dev_wdata, 32'd0);
        check_output("rst_hwint", 32'(bus.hw_int), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed writes, reads and decode errors.
        apply_stimulus(1'b1, 32'h7F00, 32'h9, 1'b0, rd_dummy);
        dev_vals[1] = 32'h1234;
        load_devs();
        apply_stimulus(1'b0, 32'h7F14, 32'h0, 1'b0, rd_dummy);
        check_output("read_1234", rd_dummy, 32'h1234);
        apply_stimulus(1'b0, 32'h7F0C, 32'h0, 1'b0, rd_dummy);
        apply_stimulus(1'b0, 32'h7F40, 32'h0, 1'b0, rd_dummy);
        apply_stimulus(1'b1, 32'h7F2C, 32'hDEAD, 1'b0, rd_dummy);
        apply_stimulus(1'b1, 32'h7F28, 32'hBEEF, 1'b0, rd_dummy);

        // Interrupt path and mask register.
        bus.dev_irq = 3'b101;
        @(negedge clk);
        check_output("irq_before", 32'(bus.hw_int), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_output("irq_after", 32'(bus.hw_int), 32'b000101);
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 32'h7F30, 32'h1, 1'b0, rd_dummy);
        @(negedge clk);
        check_output("irq_masked", 32'(bus.hw_int), 32'b000001);
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 32'h7F30, 32'h0, 1'b0, rd_dummy);
        check_output("mask_read", rd_dummy, 32'h1);

        // Back-to-back with cpu_req held high.
        apply_stimulus(1'b1, 32'h7F10, 32'h11, 1'b1, rd_dummy);
        apply_stimulus(1'b0, 32'h7F20, 32'h0, 1'b1, rd_dummy);
        apply_stimulus(1'b1, 32'h7F24, 32'h33, 1'b0, rd_dummy);

        // Reset during the ACCESS cycle of a write.
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h7F04;
        bus.cpu_wdata = 32'h55;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_output("rstacc_we", 32'(bus.dev_we), 32'd0);
        check_output("rstacc_ready", 32'(bus.cpu_ready), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.cpu_req = 1'b0;
        mask_m      = 6'b111111;
        @(negedge clk);
        check_output("post_ready", 32'(bus.cpu_ready), 32'd0);
        check_output("post_err", 32'(bus.cpu_err), 32'd0);
        check_output("post_rdata", bus.cpu_rdata, 32'd0);
        check_output("post_we", 32'(bus.dev_we), 32'd0);
        check_output("post_daddr", 32'(bus.dev_addr), 32'd0);
        check_output("post_dwdata", bus.dev_wdata, 32'd0);
        check_output("post_hwint", 32'(bus.hw_int), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_output("post2_ready", 32'(bus.cpu_ready), 32'd0);
        check_output("post2_we", 32'(bus.dev_we), 32'd0);
        @(posedge clk);
        #1;

        // Random accesses across the map, the mask register and stray addresses.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            for (int i = 0; i < NDEV; i++) dev_vals[i] = $urandom;
            load_devs();
            bus.dev_irq = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = $urandom & 32'hFFFF_FFFC;
            else                           a = BASE + 32'(4 * $urandom_range(0, 17));
            apply_stimulus(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), rd_dummy);
        end
        bus.cpu_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
